// File: rtl/wb_pipe.sv
// ============================================================================
// wb_pipe : registered writeback stage (result select, load align/extend,
//           register-file write strobe and retire counter)
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_pipe #(
   parameter  int DATA_W = 32,
   parameter  int REG_AW = 5,
   parameter  int CNT_W  = 32,
   localparam int OFF_W  = $clog2(DATA_W / 8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              flush,
   input  logic              reg_write,
   input  logic [REG_AW-1:0] rd_addr,
   input  logic [1:0]        wb_sel,
   input  logic [DATA_W-1:0] alu_res,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0] link_pc,
   input  logic [1:0]        ld_size,
   input  logic              ld_unsigned,
   input  logic [OFF_W-1:0]  byte_off,
   output logic              wr_en,
   output logic [REG_AW-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [CNT_W-1:0]  retire_cnt
);

   localparam logic [1:0] SEL_ALU  = 2'b00;
   localparam logic [1:0] SEL_MEM  = 2'b01;
   localparam logic [1:0] SEL_LINK = 2'b10;
   localparam logic [1:0] SEL_RSVD = 2'b11;

   logic              wr_en_d,      wr_en_q;
   logic [REG_AW-1:0] wr_addr_d,    wr_addr_q;
   logic [DATA_W-1:0] wr_data_d,    wr_data_q;
   logic [CNT_W-1:0]  retire_cnt_d, retire_cnt_q;

   logic              accept;
   logic [1:0]        size_eff;
   logic [OFF_W-1:0]  off_keep;
   logic [OFF_W-1:0]  off_eff;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] lane_mask;
   logic              sign_bit;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] result;

   // Load alignment: drop the offset bits below the access size, shift the
   // lane down to bit 0, then mask and extend.
   always_comb begin
      size_eff  = ((DATA_W == 32) && (ld_size == 2'b11)) ? 2'b10 : ld_size;
      off_keep  = '0;
      lane_mask = '1;
      sign_bit  = 1'b0;
      case (size_eff)
         2'b00:   off_keep = '1;
         2'b01:   off_keep = ~OFF_W'(1);
         2'b10:   off_keep = ~OFF_W'(3);
         default: off_keep = '0;
      endcase
      off_eff = byte_off & off_keep;
      shifted = mem_rdata >> {off_eff, 3'b000};
      case (size_eff)
         2'b00: begin
            lane_mask = DATA_W'(8'hFF);
            sign_bit  = shifted[7];
         end
         2'b01: begin
            lane_mask = DATA_W'(16'hFFFF);
            sign_bit  = shifted[15];
         end
         2'b10: begin
            lane_mask = DATA_W'(32'hFFFF_FFFF);
            sign_bit  = shifted[31];
         end
         default: begin
            lane_mask = '1;
            sign_bit  = shifted[DATA_W-1];
         end
      endcase
      load_data = (shifted & lane_mask) |
                  ((sign_bit && !ld_unsigned) ? ~lane_mask : '0);
   end

   always_comb begin
      result = '0;
      case (wb_sel)
         SEL_ALU:  result = alu_res;
         SEL_MEM:  result = load_data;
         SEL_LINK: result = link_pc;
         default:  result = '0;
      endcase
   end

   // Address/data only move on a real write; bubbles and non-writing
   // retirements leave the last written values on the bus.
   always_comb begin
      accept       = in_valid && !flush;
      wr_en_d      = accept && reg_write && (rd_addr != '0) && (wb_sel != SEL_RSVD);
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      retire_cnt_d = retire_cnt_q;
      if (wr_en_d) begin
         wr_addr_d = rd_addr;
         wr_data_d = result;
      end
      if (accept) begin
         retire_cnt_d = retire_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         retire_cnt_q <= '0;
      end else begin
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign retire_cnt = retire_cnt_q;

endmodule

`default_nettype wire

// File: doc/wb_pipe.md
WB_PIPE -- requirements
Module: wb_pipe

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter REG_AW, default 5, register-file address width.
REQ-003 Parameter CNT_W, default 32, retire-counter width.
REQ-004 Parameter OFF_W is derived as log2(DATA_W/8) and SHALL NOT be overridden.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 in_valid  in  1  instruction present from MEM stage this cycle.
REQ-008 flush  in  1  discard the incoming instruction.
REQ-009 reg_write  in  1  instruction writes a register.
REQ-010 rd_addr  in  REG_AW  destination register.
REQ-011 wb_sel  in  2  result source: 00 ALU, 01 memory, 10 link PC, 11 reserved.
REQ-012 alu_res  in  DATA_W  ALU result.
REQ-013 mem_rdata  in  DATA_W  raw memory read word, little-endian lanes.
REQ-014 link_pc  in  DATA_W  return address for link instructions.
REQ-015 ld_size  in  2  00 byte, 01 half, 10 word, 11 doubleword.
REQ-016 ld_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
REQ-017 byte_off  in  OFF_W  load byte offset within the word.
REQ-018 wr_en  out  1  register-file write strobe.
REQ-019 wr_addr  out  REG_AW  register-file write address.
REQ-020 wr_data  out  DATA_W  register-file write data.
REQ-021 retire_cnt  out  CNT_W  count of retired instructions.

Function
REQ-022 The block SHALL capture its inputs on each rising clk edge; all outputs are registered, with latency exactly 1 cycle from input to wr_* outputs.
REQ-023 An instruction is accepted when in_valid=1 and flush=0; flush=1 SHALL override in_valid and load a bubble.
REQ-024 A bubble cycle SHALL drive wr_en=0 and hold wr_addr/wr_data at their previous values.
REQ-025 wr_en SHALL be 1 only for an accepted instruction with reg_write=1, rd_addr!=0 and wb_sel!=11.
REQ-026 wb_sel=11 SHALL produce wr_en=0 but SHALL still count as retired.
REQ-027 Source 00 SHALL pass alu_res unchanged; 10 SHALL pass link_pc unchanged.
REQ-028 Source 01 SHALL extract the lane at byte_off: byte uses byte_off in full, half ignores byte_off[0], word ignores byte_off[1:0], doubleword ignores byte_off.
REQ-029 Extracted data SHALL be zero- or sign-extended to DATA_W according to ld_unsigned.
REQ-030 With DATA_W=32, ld_size=11 SHALL be treated as word.
REQ-031 retire_cnt SHALL increment by 1 for every accepted instruction, regardless of reg_write or rd_addr, and SHALL wrap from all-ones to 0.
REQ-032 Flushed and invalid cycles SHALL NOT change retire_cnt.

Reset
REQ-033 On rst=1, the block SHALL immediately (asynchronously) drive wr_en=0, wr_addr=0, wr_data=0 and retire_cnt=0.
REQ-034 An instruction captured in the cycle rst asserts SHALL be lost and never written.
REQ-035 The first instruction accepted after rst deasserts SHALL be captured on the first rising edge at which rst=0.

Verification
REQ-036 ALU path: wb_sel=00, alu_res=0x12345678, rd=5 -> next cycle wr_en=1, wr_addr=5, wr_data=0x12345678, retire_cnt=1.
REQ-037 Signed byte load: mem_rdata=0x80FF7F01, ld_size=00, byte_off=3, ld_unsigned=0 -> wr_data=0xFFFFFF80; with ld_unsigned=1 -> 0x00000080.
REQ-038 Half load: mem_rdata=0x8001ABCD, ld_size=01, byte_off=3, ld_unsigned=0 -> wr_data=0xFFFF8001.
REQ-039 $0 and flush: rd=0 with reg_write=1 -> wr_en=0 and retire_cnt increments; in_valid=1 with flush=1 -> wr_en=0 and retire_cnt unchanged.
REQ-040 Counter wrap: CNT_W=4 with 16 accepted instructions -> retire_cnt returns to 0.
REQ-041 Reset mid-stream: rst pulsed between clock edges while wr_en=1 -> outputs go to 0 before the next edge, and the instruction presented during reset is not written.
